// File: rtl/riscv_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the FSM encoding and the default tuning parameters.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_XFER = 2'd1,
        ST_DM_XFER = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_DM_BURST_DEF = 4;
    localparam int unsigned TIMEOUT_DEF      = 64;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Transfer watchdog: counts transfer cycles that pass without an ack.
// expired_o is high during the TIMEOUT-th such cycle.
module arb_timeout_cnt
    import riscv_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = cnt_width(TIMEOUT);

    logic [W-1:0] cnt_q;

    assign expired_o = (cnt_q == W'(TIMEOUT - 1));

    // Clear on grant, count waiting cycles, park once expired.
    always_ff @(posedge clk) begin
        if (rset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-memory requests onto one memory port.
// Data is favoured, but fetch wins after a capped run of data grants.
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned MAX_DM_BURST = MAX_DM_BURST_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        core_stall,
    output logic        err
);

    localparam int unsigned BW = cnt_width(MAX_DM_BURST);

    arb_state_e    state_q;
    logic [BW-1:0] burst_q;
    logic          if_ack_q;
    logic          dm_ack_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          err_q;

    logic          burst_full;
    logic          grant_open;
    logic          grant_dm;
    logic          grant_if;
    logic          in_xfer;
    logic          tmo_exp;
    logic [31:0]   xfer_rdata_d;

    assign burst_full = (burst_q == BW'(MAX_DM_BURST));

    // A requester still holds its request during its ack cycle,
    // so no grant is made until the cycle after an ack.
    assign grant_open = (state_q == ST_IDLE) && !if_ack_q && !dm_ack_q;
    assign grant_dm   = grant_open && dm_req && !(if_req && burst_full);
    assign grant_if   = grant_open && if_req && !grant_dm;
    assign in_xfer    = (state_q != ST_IDLE);

    assign xfer_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rset      (rset),
        .clear_i   (grant_dm | grant_if),
        .en_i      (in_xfer & ~mem_ack),
        .expired_o (tmo_exp)
    );

    // Arbitration FSM with registered memory-side and requester outputs.
    always_ff @(posedge clk) begin
        if (rset) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        state_q     <= ST_DM_XFER;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= {24'b0, dm_addr};
                        mem_wdata_q <= dm_wdata;
                        if (!burst_full) begin
                            burst_q <= burst_q + BW'(1);
                        end
                    end else if (grant_if) begin
                        state_q     <= ST_IF_XFER;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        burst_q     <= '0;
                    end
                end
                ST_IF_XFER, ST_DM_XFER: begin
                    if (mem_ack || tmo_exp) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (state_q == ST_IF_XFER) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= xfer_rdata_d;
                        end else begin
                            dm_ack_q   <= 1'b1;
                            dm_rdata_q <= xfer_rdata_d;
                        end
                        if (!mem_ack) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_ack     = if_ack_q;
    assign dm_ack     = dm_ack_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;
    assign core_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a cycle model.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 64;

    logic        clk;
    logic        rset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        core_stall;
    logic        err;

    mem_port_arbiter dut (
        .clk        (clk),
        .rset       (rset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .core_stall (core_stall),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        cmp(nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          owner = 0;   // 0 none, 1 fetch, 2 data
    int          waitc = 0;   // transfer cycles seen without ack
    int          burst = 0;   // data grants since the last fetch grant
    bit          e_if_ack = 0, e_dm_ack = 0;
    bit          e_mem_req = 0, e_mem_we = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_if_rd = 0, e_dm_rd = 0;
    bit          was_ack;
    logic [31:0] done_rd;

    always @(posedge clk) begin
        if (rset) begin
            owner = 0; waitc = 0; burst = 0;
            e_if_ack = 0; e_dm_ack = 0; e_mem_req = 0; e_mem_we = 0;
            e_addr = 0; e_wdata = 0; e_if_rd = 0; e_dm_rd = 0; e_err = 0;
        end else begin
            was_ack = e_if_ack | e_dm_ack;
            e_if_ack = 0;
            e_dm_ack = 0;
            if (owner != 0) begin
                if (mem_ack || waitc + 1 == TMO) begin
                    done_rd = (mem_ack && !e_mem_we) ? mem_rdata : 32'h0;
                    if (!mem_ack) e_err = 1;
                    if (owner == 1) begin
                        e_if_ack = 1; e_if_rd = done_rd;
                    end else begin
                        e_dm_ack = 1; e_dm_rd = done_rd;
                    end
                    owner = 0;
                    e_mem_req = 0;
                end else begin
                    waitc++;
                end
            end else if (!was_ack && (if_req || dm_req)) begin
                if (dm_req && !(if_req && burst == MAXB)) begin
                    owner = 2;
                    burst = (burst < MAXB) ? burst + 1 : MAXB;
                    e_mem_we = dm_we;
                    e_addr = {24'h0, dm_addr};
                    e_wdata = dm_wdata;
                end else begin
                    owner = 1;
                    burst = 0;
                    e_mem_we = 0;
                    e_addr = if_addr;
                    e_wdata = 0;
                end
                e_mem_req = 1;
                waitc = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            cmp("if_ack", {31'h0, if_ack}, {31'h0, e_if_ack});
            cmp("dm_ack", {31'h0, dm_ack}, {31'h0, e_dm_ack});
            cmp("mem_req", {31'h0, mem_req}, {31'h0, e_mem_req});
            cmp("err", {31'h0, err}, {31'h0, e_err});
            cmp("core_stall", {31'h0, core_stall},
                {31'h0, (if_req & ~e_if_ack) | (dm_req & ~e_dm_ack)});
            if (e_if_ack) cmp("if_rdata", if_rdata, e_if_rd);
            if (e_dm_ack) cmp("dm_rdata", dm_rdata, e_dm_rd);
            if (e_mem_req) begin
                cmp("mem_we", {31'h0, mem_we}, {31'h0, e_mem_we});
                cmp("mem_addr", mem_addr, e_addr);
                cmp("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    // ---------------- agents ----------------
    bit          rnd = 0;
    bit          if_keep = 0, dm_keep = 0;
    int          ack_delay = 0;   // >=0 fixed, -1 random, -2 never
    int          ack_mod = 3;
    int          since = 0;
    logic [31:0] rd_val = 0;
    bit          keep;

    task automatic drive();
        if (rnd) begin
            if (rset) rset = 1'b0;
            else if ($urandom_range(0, 699) == 0) rset = 1'b1;
        end
        if (!mem_req) since = 0;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (ack_delay >= 0) begin
                if (since == ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = rd_val;
                end
            end else if (ack_delay == -1 &&
                         $urandom_range(0, ack_mod - 1) == 0) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
            end
            since++;
        end else if (rnd && $urandom_range(0, 39) == 0) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
        end
        if (if_req && if_ack) begin
            keep = rnd ? ($urandom_range(0, 1) == 1) : if_keep;
            if (!keep) if_req = 1'b0;
            else if (rnd) if_addr = $urandom;
        end else if (rnd && !if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
        end else if (rnd && if_req && owner != 1 &&
                     $urandom_range(0, 15) == 0) begin
            if_req = 1'b0;
        end
        if (dm_req && dm_ack) begin
            keep = rnd ? ($urandom_range(0, 1) == 1) : dm_keep;
            if (!keep) dm_req = 1'b0;
            else if (rnd) begin
                dm_we = 1'($urandom); dm_addr = 8'($urandom);
                dm_wdata = $urandom;
            end
        end else if (rnd && !dm_req && $urandom_range(0, 3) == 0) begin
            dm_req = 1'b1; dm_we = 1'($urandom);
            dm_addr = 8'($urandom); dm_wdata = $urandom;
        end else if (rnd && dm_req && owner != 2 &&
                     $urandom_range(0, 15) == 0) begin
            dm_req = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        drive();
    endtask

    logic [31:0] cap_rd, cap_addr, cap_wd;
    logic        cap_we;

    task automatic wait_ack(input int who, input int maxc,
                            output int nreq, output bit ok);
        ok = 0;
        nreq = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                nreq++;
                cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
            end
            if ((who == 1 && if_ack) || (who == 2 && dm_ack)) begin
                ok = 1;
                cap_rd = (who == 1) ? if_rdata : dm_rdata;
            end
            drive();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (if_req || dm_req || mem_req); i++)
            tick();
        lit("drain_done", {31'h0, if_req | dm_req | mem_req}, 32'h0);
    endtask

    int    n;
    bit    ok;
    string got;

    initial begin
        rset = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ack = 0;
        chk_en = 1;
        tick(); tick();
        lit("rst_mem_req", {31'h0, mem_req}, 32'h0);
        lit("rst_mem_addr", mem_addr, 32'h0);
        lit("rst_mem_wdata", mem_wdata, 32'h0);
        lit("rst_if_rdata", if_rdata, 32'h0);
        lit("rst_err", {31'h0, err}, 32'h0);
        rset = 0;
        tick();

        // fetch with ack two cycles after mem_req rises
        ack_delay = 2; rd_val = 32'h00A00093;
        if_addr = 32'h40; if_req = 1;
        wait_ack(1, 20, n, ok);
        lit("if_ack_seen", {31'h0, ok}, 32'h1);
        lit("if_rdata_val", cap_rd, 32'h00A00093);
        lit("if_mem_addr", cap_addr, 32'h40);
        lit("if_mem_cycles", n, 3);
        tick();
        lit("stall_after_ack", {31'h0, core_stall}, 32'h0);
        tick();

        // data write
        ack_delay = 1; rd_val = 32'h5555_AAAA;
        dm_we = 1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF; dm_req = 1;
        wait_ack(2, 20, n, ok);
        lit("dm_ack_seen", {31'h0, ok}, 32'h1);
        lit("dm_mem_we", {31'h0, cap_we}, 32'h1);
        lit("dm_mem_addr", cap_addr, 32'h10);
        lit("dm_mem_wdata", cap_wd, 32'hDEADBEEF);
        lit("dm_rdata_wr", cap_rd, 32'h0);
        tick();

        // both requests held: burst cap forces a fetch every 5th grant
        rset = 1; tick(); rset = 0;
        ack_delay = 0; rd_val = 32'h1;
        if_keep = 1; dm_keep = 1; dm_we = 0; dm_addr = 8'h20;
        if_addr = 32'h100; if_req = 1; dm_req = 1;
        got = "";
        for (int i = 0; i < 300 && got.len() < 10; i++) begin
            @(negedge clk);
            #1;
            if (dm_ack) got = {got, "D"};
            if (if_ack) got = {got, "I"};
            drive();
        end
        vectors++;
        if (got != "DDDDIDDDDI") begin
            miscompares++;
            $display("FAIL grant_order: got %s expected DDDDIDDDDI", got);
        end
        if_keep = 0; dm_keep = 0;
        drain();

        // fetch never acked: abort after TMO transfer cycles
        ack_delay = -2;
        if_addr = 32'h200; if_req = 1;
        wait_ack(1, 200, n, ok);
        lit("tmo_ack_seen", {31'h0, ok}, 32'h1);
        lit("tmo_cycles", n, 64);
        lit("tmo_rdata", cap_rd, 32'h0);
        lit("tmo_err", {31'h0, err}, 32'h1);
        repeat (5) tick();
        lit("tmo_err_held", {31'h0, err}, 32'h1);
        rset = 1; tick(); rset = 0;
        lit("err_cleared", {31'h0, err}, 32'h0);
        tick();

        // reset in the middle of a data transfer
        dm_we = 0; dm_addr = 8'h22; dm_req = 1;
        repeat (4) tick();
        lit("mid_mem_req", {31'h0, mem_req}, 32'h1);
        rset = 1; dm_req = 0;
        tick();
        rset = 0;
        lit("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
        lit("rst_mid_dm_ack", {31'h0, dm_ack}, 32'h0);
        lit("rst_mid_addr", mem_addr, 32'h0);
        ack_delay = 0; rd_val = 32'h13;
        if_addr = 32'h80; if_req = 1;
        wait_ack(1, 20, n, ok);
        lit("post_rst_if_ack", {31'h0, ok}, 32'h1);
        lit("post_rst_rdata", cap_rd, 32'h13);
        tick();

        // ack arrives exactly in the expiry cycle
        ack_delay = 63; rd_val = 32'h1234;
        dm_we = 0; dm_addr = 8'h33; dm_req = 1;
        wait_ack(2, 200, n, ok);
        lit("edge_ack_seen", {31'h0, ok}, 32'h1);
        lit("edge_cycles", n, 64);
        lit("edge_rdata", cap_rd, 32'h1234);
        lit("edge_err", {31'h0, err}, 32'h0);
        tick();

        // randomized traffic, quick then slow memory
        rnd = 1; ack_delay = -1; ack_mod = 3;
        repeat (3000) tick();
        ack_mod = 90;
        repeat (3000) tick();
        rnd = 0; rset = 0; ack_delay = 0;
        drain();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DM_BURST, default 4: consecutive data grants allowed while fetch waits.
REQ-002 Parameter TIMEOUT, default 64: cycles in a transfer without mem_ack before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rset  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-006 if_addr  input  32  fetch address (PC), stable while if_req.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched instruction, valid with if_ack.
REQ-009 dm_req  input  1  data request, held until dm_ack.
REQ-010 dm_we  input  1  data write enable, stable while dm_req.
REQ-011 dm_addr  input  8  data address, stable while dm_req.
REQ-012 dm_wdata  input  32  store data, stable while dm_req.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data, valid with dm_ack.
REQ-015 mem_req  output  1  shared-memory request, held for the whole transfer.
REQ-016 mem_we  output  1  shared-memory write enable.
REQ-017 mem_addr  output  32  shared-memory address.
REQ-018 mem_wdata  output  32  shared-memory write data.
REQ-019 mem_rdata  input  32  shared-memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  shared-memory one-cycle completion pulse.
REQ-021 core_stall  output  1  pipeline stall to core.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 FSM states IDLE, IF_XFER, DM_XFER; all outputs except core_stall registered.
REQ-024 IDLE with only if_req: enter IF_XFER next cycle; mem_req=1, mem_we=0, mem_addr=if_addr latched.
REQ-025 IDLE with only dm_req: enter DM_XFER; mem_we=dm_we, mem_addr={24'b0,dm_addr}, mem_wdata=dm_wdata, all latched.
REQ-026 IDLE with both requests: data wins unless burst counter equals MAX_DM_BURST, then fetch wins.
REQ-027 Burst counter: +1 on each data grant, saturates at MAX_DM_BURST, clears on any fetch grant.
REQ-028 mem_req, mem_we, mem_addr, mem_wdata remain constant throughout a transfer.
REQ-029 mem_ack in XFER: next cycle requester ack=1, rdata=mem_rdata captured (0 for writes), mem_req=0, state IDLE.
REQ-030 Minimum occupancy: grant cycle, >=1 mem_req cycle, ack cycle; new grant no earlier than the cycle after an ack.
REQ-031 mem_ack in IDLE is ignored.
REQ-032 Timeout counter clears on entry to XFER, increments each XFER cycle without mem_ack; at TIMEOUT: requester ack=1, rdata=0, err=1, mem_req=0, state IDLE.
REQ-033 mem_ack on the same cycle as timeout expiry: treated as normal completion, err unchanged.
REQ-034 core_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
REQ-035 Requests withdrawn before grant are dropped without side effect; withdrawal after grant is a protocol violation, transfer completes anyway.

Reset
REQ-036 rset=1 at a clock edge: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, burst and timeout counters=0, err=0.
REQ-037 Reset mid-transfer abandons it; no ack issued; mem_req low on the cycle after the reset edge.
REQ-038 err clears only on reset.

Structure
REQ-039 Package riscv_arb_pkg holds FSM state encoding and MAX_DM_BURST/TIMEOUT defaults.
REQ-040 Timeout counter is sub-module arb_timeout_cnt (clear, enable, expired output); everything else is in mem_port_arbiter.

Verification
REQ-041 if_req=1, if_addr=0x40, mem_ack 2 cycles after mem_req with rdata 0x00A00093 -> mem_addr=0x40, if_ack pulse with if_rdata=0x00A00093, core_stall low after ack.
REQ-042 dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x00000010, mem_wdata=0xDEADBEEF, dm_ack with dm_rdata=0.
REQ-043 Both requests held continuously, memory acks in 1 cycle -> grant order DM,DM,DM,DM,IF,DM... (4 data grants, then 1 fetch).
REQ-044 if_req with mem_ack never asserted -> if_ack at cycle TIMEOUT=64 of IF_XFER, if_rdata=0, err=1 and held.
REQ-045 rset pulsed during DM_XFER -> no dm_ack, mem_req=0 next cycle, all outputs at reset values, new if_req served normally.
REQ-046 mem_ack on the same cycle as timeout expiry with rdata 0x1234 -> normal ack with rdata 0x1234, err stays 0.
